// File: rtl/signal_phase_scheduler.sv
// ---------------------------------------------------------------------------
// signal_phase_scheduler : two-road phase sequencer with ped, preempt, night
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module signal_phase_scheduler #(
  parameter int CW       = 6,
  parameter int GREEN_T  = 25,
  parameter int YELLOW_T = 5,
  parameter int ALLRED_T = 2,
  parameter int PED_CUT  = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          ped_req1,
  input  logic          ped_req2,
  input  logic          emerg_req,
  input  logic          emerg_dir,
  input  logic          night_mode,
  output logic [2:0]    light1,
  output logic [2:0]    light2,
  output logic          ped_walk1,
  output logic          ped_walk2,
  output logic [CW-1:0] remain,
  output logic [2:0]    phase
);

  typedef enum logic [2:0] {
    AR1   = 3'd0,
    G1    = 3'd1,
    Y1    = 3'd2,
    AR2   = 3'd3,
    G2    = 3'd4,
    Y2    = 3'd5,
    EMERG = 3'd6,
    NIGHT = 3'd7
  } state_t;

  localparam logic [CW-1:0] GREEN_LD  = CW'(GREEN_T - 1);
  localparam logic [CW-1:0] YELLOW_LD = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] ALLRED_LD = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] PED_LD    = CW'(PED_CUT);
  localparam logic [2:0]    LAMP_R    = 3'b100;
  localparam logic [2:0]    LAMP_Y    = 3'b010;
  localparam logic [2:0]    LAMP_G    = 3'b001;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pend1, pend2, walk1, walk2, emerg_road, flash;
  logic          walk1_n, walk2_n, emerg_road_n, flash_n, clr1, clr2;
  logic          expired;

  assign expired = tick && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= AR1;
      cnt        <= ALLRED_LD;
      pend1      <= 1'b0;
      pend2      <= 1'b0;
      walk1      <= 1'b0;
      walk2      <= 1'b0;
      emerg_road <= 1'b0;
      flash      <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pend1      <= ped_req1 | (pend1 & ~clr1);
      pend2      <= ped_req2 | (pend2 & ~clr2);
      walk1      <= walk1_n;
      walk2      <= walk2_n;
      emerg_road <= emerg_road_n;
      flash      <= flash_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    walk1_n      = walk1;
    walk2_n      = walk2;
    emerg_road_n = emerg_road;
    flash_n      = flash;
    clr1         = 1'b0;
    clr2         = 1'b0;
    case (state)
      AR1, AR2: begin
        if (expired) begin
          if (emerg_req) begin
            state_n      = EMERG;
            cnt_n        = '0;
            emerg_road_n = emerg_dir;
          end else if (night_mode) begin
            state_n = NIGHT;
            cnt_n   = '0;
            flash_n = 1'b1;
          end else if (state == AR1) begin
            // Road 1 green serves pedestrians crossing road 2.
            state_n = G1;
            cnt_n   = GREEN_LD;
            walk2_n = pend2;
            clr2    = 1'b1;
          end else begin
            state_n = G2;
            cnt_n   = GREEN_LD;
            walk1_n = pend1;
            clr1    = 1'b1;
          end
        end else if (tick) begin
          cnt_n = cnt - CW'(1);
        end
      end
      G1, G2: begin
        if (emerg_req && (emerg_dir == (state == G2))) begin
          state_n      = EMERG;
          cnt_n        = '0;
          emerg_road_n = emerg_dir;
        end else if (emerg_req || expired) begin
          state_n = (state == G1) ? Y1 : Y2;
          cnt_n   = YELLOW_LD;
        end else if (tick) begin
          if (((state == G1) ? pend1 : pend2) && (cnt > PED_LD))
            cnt_n = PED_LD;
          else
            cnt_n = cnt - CW'(1);
        end
      end
      Y1, Y2: begin
        if (expired) begin
          state_n = (state == Y1) ? AR2 : AR1;
          cnt_n   = ALLRED_LD;
        end else if (tick) begin
          cnt_n = cnt - CW'(1);
        end
      end
      EMERG: begin
        cnt_n = '0;
        if (!emerg_req) begin
          state_n = emerg_road ? Y2 : Y1;
          cnt_n   = YELLOW_LD;
        end
      end
      default: begin
        cnt_n = '0;
        if (emerg_req || !night_mode) begin
          state_n = AR1;
          cnt_n   = ALLRED_LD;
        end else if (tick) begin
          flash_n = ~flash;
        end
      end
    endcase
  end

  always_comb begin
    light1    = LAMP_R;
    light2    = LAMP_R;
    ped_walk1 = 1'b0;
    ped_walk2 = 1'b0;
    case (state)
      G1:    begin light1 = LAMP_G; ped_walk2 = walk2; end
      Y1:    light1 = LAMP_Y;
      G2:    begin light2 = LAMP_G; ped_walk1 = walk1; end
      Y2:    light2 = LAMP_Y;
      EMERG: begin
        if (emerg_road) light2 = LAMP_G;
        else            light1 = LAMP_G;
      end
      NIGHT: begin
        light1 = flash ? LAMP_Y : 3'b000;
        light2 = flash ? LAMP_Y : 3'b000;
      end
      default: ;
    endcase
  end

  assign remain = cnt;
  assign phase  = state;

endmodule

`default_nettype wire

// File: tb/tb_signal_phase_scheduler.sv
// ---------------------------------------------------------------------------
// tb_signal_phase_scheduler : table-driven directed bench for the scheduler
// ---------------------------------------------------------------------------
`default_nettype none

module tb_signal_phase_scheduler;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       ped_req1 = 1'b0;
  logic       ped_req2 = 1'b0;
  logic       emerg_req = 1'b0;
  logic       emerg_dir = 1'b0;
  logic       night_mode = 1'b0;
  logic [2:0] light1, light2;
  logic       ped_walk1, ped_walk2;
  logic [5:0] remain;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;

  signal_phase_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .ped_req1   (ped_req1),
    .ped_req2   (ped_req2),
    .emerg_req  (emerg_req),
    .emerg_dir  (emerg_dir),
    .night_mode (night_mode),
    .light1     (light1),
    .light2     (light2),
    .ped_walk1  (ped_walk1),
    .ped_walk2  (ped_walk2),
    .remain     (remain),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       tk, p1, p2, em, dr, nt;
    logic [2:0] ph;
    logic [5:0] rem;
    logic [2:0] l1, l2;
    logic       w1, w2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic tk, input logic p1, input logic p2,
                     input logic em, input logic dr, input logic nt,
                     input logic [2:0] ph, input logic [5:0] rem,
                     input logic [2:0] l1, input logic [2:0] l2,
                     input logic w1, input logic w2);
    vec_t v;
    v.n = n; v.tk = tk; v.p1 = p1; v.p2 = p2; v.em = em; v.dr = dr; v.nt = nt;
    v.ph = ph; v.rem = rem; v.l1 = l1; v.l2 = l2; v.w1 = w1; v.w2 = w2;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] ph, input logic [5:0] rem,
                       input logic [2:0] l1, input logic [2:0] l2,
                       input logic w1, input logic w2);
    total++;
    if ({phase, remain, light1, light2, ped_walk1, ped_walk2} !== {ph, rem, l1, l2, w1, w2}) begin
      bad++;
      $display("FAIL %s: got phase=%0d remain=%0d l1=%b l2=%b w1=%b w2=%b, want phase=%0d remain=%0d l1=%b l2=%b w1=%b w2=%b",
               name, phase, remain, light1, light2, ped_walk1, ped_walk2, ph, rem, l1, l2, w1, w2);
    end
  endtask

  // Lamps must never both show non-red outside night flashing.
  always @(negedge clk) begin
    if (rst_n && phase != 3'd7) begin
      total++;
      if (light1 != R && light2 != R) begin
        bad++;
        $display("FAIL lamp_conflict: l1=%b l2=%b phase=%0d, want one road red", light1, light2, phase);
      end
    end
  end

  initial begin
    // normal cycle from reset
    add(1, 1,0,0,0,0,0, 0, 0, R,R,0,0);
    add(1, 1,0,0,0,0,0, 1,24, G,R,0,0);
    add(24,1,0,0,0,0,0, 1, 0, G,R,0,0);
    add(1, 1,0,0,0,0,0, 2, 4, Y,R,0,0);
    add(4, 1,0,0,0,0,0, 2, 0, Y,R,0,0);
    add(1, 1,0,0,0,0,0, 3, 1, R,R,0,0);
    add(2, 1,0,0,0,0,0, 4,24, R,G,0,0);
    add(25,1,0,0,0,0,0, 5, 4, R,Y,0,0);
    add(5, 1,0,0,0,0,0, 0, 1, R,R,0,0);
    add(2, 1,0,0,0,0,0, 1,24, G,R,0,0);
    // tick freeze, then ped_req1 shortens G1 and walks during G2
    add(4, 1,0,0,0,0,0, 1,20, G,R,0,0);
    add(10,0,0,0,0,0,0, 1,20, G,R,0,0);
    add(1, 0,1,0,0,0,0, 1,20, G,R,0,0);
    add(1, 1,0,0,0,0,0, 1, 5, G,R,0,0);
    add(5, 1,0,0,0,0,0, 1, 0, G,R,0,0);
    add(1, 1,0,0,0,0,0, 2, 4, Y,R,0,0);
    add(5, 1,0,0,0,0,0, 3, 1, R,R,0,0);
    add(2, 1,0,0,0,0,0, 4,24, R,G,1,0);
    add(24,1,0,0,0,0,0, 4, 0, R,G,1,0);
    add(1, 1,0,0,0,0,0, 5, 4, R,Y,0,0);
    add(5, 1,0,0,0,0,0, 0, 1, R,R,0,0);
    add(2, 1,0,0,0,0,0, 1,24, G,R,0,0);
    add(1, 1,0,0,0,0,0, 1,23, G,R,0,0);
    // emergency for road 2 raised in G1
    add(13,1,0,0,0,0,0, 1,10, G,R,0,0);
    add(1, 1,0,0,1,1,0, 2, 4, Y,R,0,0);
    add(5, 1,0,0,1,1,0, 3, 1, R,R,0,0);
    add(2, 1,0,0,1,1,0, 6, 0, R,G,0,0);
    add(3, 1,0,0,1,0,0, 6, 0, R,G,0,0);
    add(1, 1,0,0,0,0,0, 5, 4, R,Y,0,0);
    add(5, 1,0,0,0,0,0, 0, 1, R,R,0,0);
    add(2, 1,0,0,0,0,0, 1,24, G,R,0,0);
    // emergency for road 1 raised in G1
    add(1, 1,0,0,1,0,0, 6, 0, G,R,0,0);
    add(4, 1,0,0,1,0,0, 6, 0, G,R,0,0);
    add(1, 1,0,0,0,0,0, 2, 4, Y,R,0,0);
    add(5, 1,0,0,0,0,0, 3, 1, R,R,0,0);
    add(2, 1,0,0,0,0,0, 4,24, R,G,0,0);
    // night mode, then emergency overrides it
    add(25,1,0,0,0,0,1, 5, 4, R,Y,0,0);
    add(5, 1,0,0,0,0,1, 0, 1, R,R,0,0);
    add(2, 1,0,0,0,0,1, 7, 0, Y,Y,0,0);
    add(1, 1,0,0,0,0,1, 7, 0, O,O,0,0);
    add(1, 0,0,0,0,0,1, 7, 0, O,O,0,0);
    add(1, 1,0,0,0,0,1, 7, 0, Y,Y,0,0);
    add(1, 1,0,0,1,1,1, 0, 1, R,R,0,0);
    add(2, 1,0,0,1,1,1, 6, 0, R,G,0,0);
    add(1, 1,0,0,0,0,0, 5, 4, R,Y,0,0);
    add(5, 1,0,0,0,0,0, 0, 1, R,R,0,0);
    add(2, 1,0,0,0,0,0, 1,24, G,R,0,0);
    // ped_req2 during G1 is held, shortens G2, walks during next G1
    add(1, 0,0,1,0,0,0, 1,24, G,R,0,0);
    add(25,1,0,0,0,0,0, 2, 4, Y,R,0,0);
    add(5, 1,0,0,0,0,0, 3, 1, R,R,0,0);
    add(2, 1,0,0,0,0,0, 4,24, R,G,0,0);
    add(1, 1,0,0,0,0,0, 4, 5, R,G,0,0);
    add(6, 1,0,0,0,0,0, 5, 4, R,Y,0,0);
    add(5, 1,0,0,0,0,0, 0, 1, R,R,0,0);
    add(2, 1,0,0,0,0,0, 1,24, G,R,0,1);
    add(25,1,0,0,0,0,0, 2, 4, Y,R,0,0);
    // run into the middle of Y2
    add(5, 1,0,0,0,0,0, 3, 1, R,R,0,0);
    add(2, 1,0,0,0,0,0, 4,24, R,G,0,0);
    add(25,1,0,0,0,0,0, 5, 4, R,Y,0,0);
    add(2, 1,0,0,0,0,0, 5, 2, R,Y,0,0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_values", 3'd0, 6'd1, R, R, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick  = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      tick = vecs[i].tk; ped_req1 = vecs[i].p1; ped_req2 = vecs[i].p2;
      emerg_req = vecs[i].em; emerg_dir = vecs[i].dr; night_mode = vecs[i].nt;
      repeat (vecs[i].n) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].ph, vecs[i].rem, vecs[i].l1, vecs[i].l2,
            vecs[i].w1, vecs[i].w2);
    end

    // asynchronous reset mid-Y2 takes effect without a clock edge
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 3'd0, 6'd1, R, R, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold", 3'd0, 6'd1, R, R, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_g1", 3'd1, 6'd24, G, R, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
